restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand and result width in bits; legal range 2..16.
REQ-002 SHALL provide port CLK  input  1  rising-edge clock; the only clock.
REQ-003 SHALL provide port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port START  input  1  request to begin a division, sampled on CLK rising edge.
REQ-005 SHALL provide port DIVIDEND  input  WIDTH  unsigned numerator, sampled with START.
REQ-006 SHALL provide port DIVISOR  input  WIDTH  unsigned denominator, sampled with START.
REQ-007 SHALL provide port BUSY  output  1  high while a division is in progress.
REQ-008 SHALL provide port DONE  output  1  single-cycle pulse marking QUOTIENT/REMAINDER valid.
REQ-009 SHALL provide port QUOTIENT  output  WIDTH  unsigned floor(DIVIDEND/DIVISOR).
REQ-010 SHALL provide port REMAINDER  output  WIDTH  unsigned DIVIDEND mod DIVISOR.
REQ-011 SHALL provide port DIVZ  output  1  divide-by-zero flag, present only per REQ-027.

Function
REQ-012 SHALL implement states IDLE, RUN, FINISH, registered and updated on CLK rising edge.
REQ-013 SHALL, in IDLE or FINISH with START=1 at an edge, latch DIVIDEND/DIVISOR, clear the iteration counter and partial remainder, and enter RUN.
REQ-014 SHALL ignore START while in RUN, with no effect on latched operands, counter or outputs.
REQ-015 SHALL perform one restoring iteration per RUN edge: shift the next dividend MSB into the partial remainder, then trial-subtract the divisor at WIDTH+1 bits.
REQ-016 SHALL implement the trial subtraction as an add of the inverted divisor with carry-in 1; carry-out 1 (no borrow) commits the difference and shifts in quotient bit 1, otherwise it restores the remainder and shifts in quotient bit 0.
REQ-017 SHALL execute exactly WIDTH iterations, then enter FINISH; QUOTIENT and REMAINDER update on that same edge.
REQ-018 SHALL hold DONE high for exactly the one cycle spent in FINISH, and leave FINISH for IDLE unless START is high (REQ-013).
REQ-019 SHALL hold BUSY high in RUN only, from the edge sampling START until the edge entering FINISH (WIDTH cycles).
REQ-020 SHALL keep QUOTIENT and REMAINDER stable from FINISH until the next FINISH or RESET.
REQ-021 SHALL produce, for DIVISOR=0 without the REQ-027 feature, QUOTIENT all-ones and REMAINDER=DIVIDEND after the normal WIDTH-cycle latency.
REQ-022 SHALL produce correct results for DIVIDEND < DIVISOR (QUOTIENT=0, REMAINDER=DIVIDEND) and for DIVISOR=1 (QUOTIENT=DIVIDEND, REMAINDER=0).

Reset
REQ-023 SHALL, on RESET high, immediately and without waiting for CLK, force state IDLE, BUSY=0, DONE=0, QUOTIENT=0, REMAINDER=0, DIVZ=0, counter=0.
REQ-024 SHALL abandon any in-progress division on RESET, with no DONE pulse for it after RESET deasserts.
REQ-025 SHALL ignore START on any edge where RESET is high.

Configuration
REQ-026 SHALL use preprocessor macro RESTORING_DIVIDER_DIVZ_EN.
REQ-027 SHALL, with RESTORING_DIVIDER_DIVZ_EN defined, include port DIVZ; DIVISOR=0 sampled with START goes directly to FINISH on the next edge (BUSY stays 0), with QUOTIENT all-ones, REMAINDER=DIVIDEND, DIVZ=1; DIVZ clears on the next accepted START.
REQ-028 SHALL, with the macro undefined, omit port DIVZ and all zero-detect logic, with DIVISOR=0 handled per REQ-021.

Verification
REQ-029 SHALL check: WIDTH=8, START with 100/7 -> BUSY for 8 cycles, DONE pulse on cycle 8, QUOTIENT=14, REMAINDER=2.
REQ-030 SHALL check: 255/1 -> 255 r 0; 5/9 -> 0 r 5; 255/255 -> 1 r 0.
REQ-031 SHALL check: 200/0 -> macro off: 255 r 200 after 8 cycles, no DIVZ port; macro on: DONE 1 cycle after START, DIVZ=1, 255 r 200.
REQ-032 SHALL check: START 50/3, START pulsed again with 9/9 on cycle 4 -> ignored, result 16 r 2 on cycle 8.
REQ-033 SHALL check: START asserted during DONE cycle with 77/10 -> no IDLE gap, BUSY next cycle, 7 r 7 eight cycles later.
REQ-034 SHALL check: RESET mid-RUN on cycle 5 -> outputs 0 at once, no DONE afterwards, next 9/4 gives 2 r 1.

Source files
------------

// File: rtl/restoring_divider.sv
// Restoring divider: unsigned WIDTH-bit DIVIDEND / DIVISOR, one quotient bit
// per clock.
// Optional feature macro: RESTORING_DIVIDER_DIVZ_EN.
// When it is defined, the module adds a DIVZ port. A zero divisor then
// finishes on the next edge and raises DIVZ.
// When it is undefined, a zero divisor runs through the normal iterations.
// That run yields an all-ones quotient with the remainder equal to the dividend.
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER
`ifdef RESTORING_DIVIDER_DIVZ_EN
  ,
  output logic             DIVZ
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   rmd_q;
`ifdef RESTORING_DIVIDER_DIVZ_EN
  logic               divz_q;
`endif

  // Working registers: remaining dividend bits (quotient bits shift in at the
  // LSB), latched divisor and partial remainder.
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dsr_q;
  logic [WIDTH-1:0]   prem_q;

  logic               accept;
  logic               last_iter;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   trial;
  logic               qbit;
  logic [WIDTH-1:0]   prem_d;
  logic [WIDTH-1:0]   dvd_d;
  logic               unused_trial_msb;

  assign accept    = START && (state_q != RUN);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // Shift the next dividend bit into the partial remainder.
  // Then trial-subtract the divisor as remainder + ~divisor + 1 at WIDTH+1 bits.
  // Carry-out set means no borrow.
  assign shifted = {prem_q, dvd_q[WIDTH-1]};
  assign trial   = {1'b0, shifted} + {1'b0, ~{1'b0, dsr_q}} + (WIDTH+2)'(1);
  assign qbit    = trial[WIDTH+1];
  // A committed difference is always below the divisor, so it fits in WIDTH bits.
  // A restored value below the divisor also fits in WIDTH bits.
  assign prem_d  = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign dvd_d   = {dvd_q[WIDTH-2:0], qbit};
  assign unused_trial_msb = trial[WIDTH];

  // Datapath: load operands on an accepted START, iterate once per RUN cycle.
  always_ff @(posedge CLK) begin
    if (accept) begin
      dvd_q  <= DIVIDEND;
      dsr_q  <= DIVISOR;
      prem_q <= '0;
    end else if (state_q == RUN) begin
      dvd_q  <= dvd_d;
      prem_q <= prem_d;
    end
  end

  // Control FSM with registered BUSY/DONE and result registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
`ifdef RESTORING_DIVIDER_DIVZ_EN
      divz_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, FINISH: begin
          if (START) begin
            cnt_q <= '0;
`ifdef RESTORING_DIVIDER_DIVZ_EN
            if (DIVISOR == '0) begin
              state_q <= FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              quo_q   <= '1;
              rmd_q   <= DIVIDEND;
              divz_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              divz_q  <= 1'b0;
            end
`else
            state_q <= RUN;
            busy_q  <= 1'b1;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (last_iter) begin
            state_q <= FINISH;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= dvd_d;
            rmd_q   <= prem_d;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign QUOTIENT  = quo_q;
  assign REMAINDER = rmd_q;
`ifdef RESTORING_DIVIDER_DIVZ_EN
  assign DIVZ      = divz_q;
`endif

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (WIDTH=8), with random operands
// checked against a plain arithmetic reference.
module tb_restoring_divider;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         START = 1'b0;
  logic [W-1:0] DIVIDEND = '0;
  logic [W-1:0] DIVISOR = '0;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] QUOTIENT;
  logic [W-1:0] REMAINDER;
`ifdef RESTORING_DIVIDER_DIVZ_EN
  logic         DIVZ;
`endif

  int checks = 0;
  int errors = 0;

  restoring_divider #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .DIVIDEND  (DIVIDEND),
    .DIVISOR   (DIVISOR),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .QUOTIENT  (QUOTIENT),
    .REMAINDER (REMAINDER)
`ifdef RESTORING_DIVIDER_DIVZ_EN
    ,
    .DIVZ      (DIVZ)
`endif
  );

  always #5 CLK = ~CLK;

  // Reference model: ordinary integer division, with the zero-divisor rule.
  function automatic logic [W-1:0] ref_q(input int a, input int b);
    return (b == 0) ? W'((1 << W) - 1) : W'(a / b);
  endfunction

  function automatic logic [W-1:0] ref_r(input int a, input int b);
    return (b == 0) ? W'(a) : W'(a % b);
  endfunction

  // Cycles from the START-sampling edge to the DONE pulse.
  function automatic int ref_lat(input int b);
`ifdef RESTORING_DIVIDER_DIVZ_EN
    if (b == 0) return 0;
`endif
    return W;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic launch(input int a, input int b);
    DIVIDEND = W'(a);
    DIVISOR  = W'(b);
    START    = 1'b1;
    step();
    START    = 1'b0;
  endtask

  // Waits (bounded) for DONE, counting cycles and cycles where BUSY was low.
  task automatic wait_done(output int cyc, output int busy_low);
    cyc = 0;
    busy_low = 0;
    while (DONE !== 1'b1 && cyc < 200) begin
      if (BUSY !== 1'b1) busy_low++;
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #2;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", DONE); end
    checks++; if (QUOTIENT !== '0) begin errors++; $display("FAIL reset_q got %0d want 0", QUOTIENT); end
    checks++; if (REMAINDER !== '0) begin errors++; $display("FAIL reset_r got %0d want 0", REMAINDER); end
`ifdef RESTORING_DIVIDER_DIVZ_EN
    checks++; if (DIVZ !== 1'b0) begin errors++; $display("FAIL reset_divz got %b want 0", DIVZ); end
`endif
    step();
    step();
    RESET = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int cyc, bl;
    launch(100, 7);
    wait_done(cyc, bl);
    checks++; if (cyc != 8) begin errors++; $display("FAIL basic_latency got %0d want 8", cyc); end
    checks++; if (bl != 0) begin errors++; $display("FAIL basic_busy low for %0d cycles want 0", bl); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", BUSY); end
    checks++; if (QUOTIENT !== 8'd14) begin errors++; $display("FAIL basic_q got %0d want 14", QUOTIENT); end
    checks++; if (REMAINDER !== 8'd2) begin errors++; $display("FAIL basic_r got %0d want 2", REMAINDER); end
    step();
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", DONE); end
    step();
    checks++; if (QUOTIENT !== 8'd14 || REMAINDER !== 8'd2)
      begin errors++; $display("FAIL basic_hold got %0d r %0d want 14 r 2", QUOTIENT, REMAINDER); end
  endtask

  task automatic test_corners();
    int av[5] = '{255, 5, 255, 0, 9};
    int bv[5] = '{1, 9, 255, 5, 1};
    int cyc, bl;
    for (int i = 0; i < 5; i++) begin
      launch(av[i], bv[i]);
      wait_done(cyc, bl);
      checks++; if (cyc != W || bl != 0)
        begin errors++; $display("FAIL corner_latency %0d/%0d got %0d (busy low %0d) want %0d", av[i], bv[i], cyc, bl, W); end
      checks++; if (QUOTIENT !== ref_q(av[i], bv[i]) || REMAINDER !== ref_r(av[i], bv[i]))
        begin errors++; $display("FAIL corner %0d/%0d got %0d r %0d want %0d r %0d", av[i], bv[i],
          QUOTIENT, REMAINDER, ref_q(av[i], bv[i]), ref_r(av[i], bv[i])); end
      step();
    end
  endtask

  task automatic test_divzero();
    int cyc, bl;
    launch(200, 0);
    wait_done(cyc, bl);
`ifdef RESTORING_DIVIDER_DIVZ_EN
    checks++; if (cyc != 0) begin errors++; $display("FAIL divz_latency got %0d want 0", cyc); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL divz_busy got %b want 0", BUSY); end
    checks++; if (DIVZ !== 1'b1) begin errors++; $display("FAIL divz_flag got %b want 1", DIVZ); end
`else
    checks++; if (cyc != 8 || bl != 0) begin errors++; $display("FAIL div0_latency got %0d (busy low %0d) want 8", cyc, bl); end
`endif
    checks++; if (QUOTIENT !== 8'd255 || REMAINDER !== 8'd200)
      begin errors++; $display("FAIL div0_result got %0d r %0d want 255 r 200", QUOTIENT, REMAINDER); end
    step();
`ifdef RESTORING_DIVIDER_DIVZ_EN
    launch(10, 3);
    checks++; if (DIVZ !== 1'b0) begin errors++; $display("FAIL divz_clear got %b want 0", DIVZ); end
    wait_done(cyc, bl);
    checks++; if (QUOTIENT !== 8'd3 || REMAINDER !== 8'd1)
      begin errors++; $display("FAIL divz_next got %0d r %0d want 3 r 1", QUOTIENT, REMAINDER); end
    step();
`endif
  endtask

  task automatic test_random();
    int a, b, cyc, bl;
    for (int i = 0; i < 25; i++) begin
      a = int'($urandom_range(0, 255));
      b = (i % 6 == 5) ? 0 : int'($urandom_range(1, 255));
      launch(a, b);
      wait_done(cyc, bl);
      checks++; if (cyc != ref_lat(b) || bl != 0)
        begin errors++; $display("FAIL rand_latency %0d/%0d got %0d (busy low %0d) want %0d", a, b, cyc, bl, ref_lat(b)); end
      checks++; if (QUOTIENT !== ref_q(a, b) || REMAINDER !== ref_r(a, b))
        begin errors++; $display("FAIL rand %0d/%0d got %0d r %0d want %0d r %0d", a, b,
          QUOTIENT, REMAINDER, ref_q(a, b), ref_r(a, b)); end
      step();
    end
  endtask

  task automatic test_ignore_start();
    int cyc, bl;
    launch(50, 3);
    step();
    step();
    step();
    DIVIDEND = 8'd9;
    DIVISOR  = 8'd9;
    START    = 1'b1;
    step();
    START    = 1'b0;
    wait_done(cyc, bl);
    checks++; if (cyc != 4 || bl != 0)
      begin errors++; $display("FAIL ignore_latency got %0d (busy low %0d) want 4", cyc, bl); end
    checks++; if (QUOTIENT !== 8'd16 || REMAINDER !== 8'd2)
      begin errors++; $display("FAIL ignore_result got %0d r %0d want 16 r 2", QUOTIENT, REMAINDER); end
    step();
    checks++; if (BUSY !== 1'b0 || DONE !== 1'b0)
      begin errors++; $display("FAIL ignore_after got busy %b done %b want 0 0", BUSY, DONE); end
  endtask

  task automatic test_back_to_back();
    int cyc, bl;
    launch(100, 7);
    wait_done(cyc, bl);
    launch(77, 10);
    checks++; if (BUSY !== 1'b1 || DONE !== 1'b0)
      begin errors++; $display("FAIL b2b_restart got busy %b done %b want 1 0", BUSY, DONE); end
    checks++; if (QUOTIENT !== 8'd14 || REMAINDER !== 8'd2)
      begin errors++; $display("FAIL b2b_hold got %0d r %0d want 14 r 2", QUOTIENT, REMAINDER); end
    wait_done(cyc, bl);
    checks++; if (cyc != 8 || bl != 0)
      begin errors++; $display("FAIL b2b_latency got %0d (busy low %0d) want 8", cyc, bl); end
    checks++; if (QUOTIENT !== 8'd7 || REMAINDER !== 8'd7)
      begin errors++; $display("FAIL b2b_result got %0d r %0d want 7 r 7", QUOTIENT, REMAINDER); end
    step();
  endtask

  task automatic test_reset_mid();
    int cyc, bl, seen;
    launch(100, 7);
    step();
    step();
    step();
    step();
    #2;
    RESET = 1'b1;
    #1;
    checks++; if (BUSY !== 1'b0 || DONE !== 1'b0)
      begin errors++; $display("FAIL rstmid_ctrl got busy %b done %b want 0 0", BUSY, DONE); end
    checks++; if (QUOTIENT !== '0 || REMAINDER !== '0)
      begin errors++; $display("FAIL rstmid_data got %0d r %0d want 0 r 0", QUOTIENT, REMAINDER); end
    DIVIDEND = 8'd9;
    DIVISOR  = 8'd4;
    START    = 1'b1;
    @(posedge CLK);
    #3;
    RESET = 1'b0;
    START = 1'b0;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_start_ignored busy %b want 0", BUSY); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (DONE !== 1'b0 || BUSY !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_quiet activity in %0d cycles want 0", seen); end
    launch(9, 4);
    wait_done(cyc, bl);
    checks++; if (cyc != 8 || QUOTIENT !== 8'd2 || REMAINDER !== 8'd1)
      begin errors++; $display("FAIL rstmid_next got %0d r %0d after %0d want 2 r 1 after 8", QUOTIENT, REMAINDER, cyc); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_divzero();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
